// File: rtl/boot_sequencer_if.sv
// Stream-in and shared memory port bundle between the boot sequencer and its surroundings.
// master = boot sequencer side, slave = stream source / memory mux side.
interface boot_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot controller: clears the instruction region, loads a streamed image, verifies it by
// checksum readback, then hands memory to the fetcher and releases the CPU.
module boot_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 16'h0100,
  parameter int                    REGION     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] len,
  boot_sequencer_if.master      bus,
  output logic                  cpu_reset_n,
  output logic                  trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);
  localparam int KW = $clog2(REGION + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_VERIFY, S_CHECK, S_RELEASE, S_RUN, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [KW-1:0]         k;
  logic [KW-1:0]         len_q;
  logic [DATA_WIDTH-1:0] wsum, rsum;
  logic                  len_bad, k_last_region, k_last_len, xfer, sum_ok;

  function automatic logic [DATA_WIDTH-1:0] sum_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign len_bad       = ({1'b0, len} > (ADDR_WIDTH + 1)'(REGION));
  assign k_last_region = (k == KW'(REGION - 1));
  assign k_last_len    = (k == len_q - KW'(1));
  assign xfer          = (state == S_LOAD) && bus.in_valid;
  // The last read's data arrives during CHECK, so the final compare folds it in directly.
  assign sum_ok        = (sum_add(rsum, bus.mem_rdata) == wsum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_ERROR: if (start) state_nx = len_bad ? S_ERROR : S_CLEAR;
      S_CLEAR:   if (k_last_region) state_nx = (len_q == '0) ? S_RELEASE : S_LOAD;
      S_LOAD:    if (xfer && k_last_len) state_nx = S_VERIFY;
      S_VERIFY:  if (k_last_len) state_nx = S_CHECK;
      S_CHECK:   state_nx = sum_ok ? S_RELEASE : S_ERROR;
      S_RELEASE: state_nx = S_RUN;
      S_RUN:     if (stop) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      len_q    <= '0;
      wsum     <= '0;
      rsum     <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            len_q    <= KW'(len);
            k        <= '0;
            wsum     <= '0;
            rsum     <= '0;
            err_code <= len_bad ? 2'b01 : 2'b00;
          end
        end
        S_CLEAR: k <= k_last_region ? '0 : k + KW'(1);
        S_LOAD: begin
          if (xfer) begin
            wsum <= sum_add(wsum, bus.in_data);
            k    <= k_last_len ? '0 : k + KW'(1);
          end
        end
        S_VERIFY: begin
          // No read was issued in the cycle before the first VERIFY cycle.
          if (k != '0) rsum <= sum_add(rsum, bus.mem_rdata);
          k <= k + KW'(1);
        end
        S_CHECK: begin
          rsum <= sum_add(rsum, bus.mem_rdata);
          if (!sum_ok) err_code <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.mem_sel   = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    cpu_reset_n   = 1'b0;
    trigger       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state)
      S_CLEAR: begin
        busy         = 1'b1;
        bus.mem_addr = BASE + ADDR_WIDTH'(k);
        bus.mem_we   = 1'b1;
      end
      S_LOAD: begin
        busy          = 1'b1;
        bus.in_ready  = 1'b1;
        bus.mem_addr  = BASE + ADDR_WIDTH'(k);
        bus.mem_wdata = bus.in_data;
        bus.mem_we    = bus.in_valid;
      end
      S_VERIFY: begin
        busy         = 1'b1;
        bus.mem_addr = BASE + ADDR_WIDTH'(k);
      end
      S_CHECK: busy = 1'b1;
      S_RELEASE: begin
        busy        = 1'b1;
        bus.mem_sel = 1'b0;
        cpu_reset_n = 1'b1;
        trigger     = 1'b1;
      end
      S_RUN: begin
        bus.mem_sel = 1'b0;
        cpu_reset_n = 1'b1;
        done        = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: table of boot scenarios, hand-written reset/stop sequences and
// randomized boots checked against a checksum/timing model derived from the boot rules.
module tb_boot_sequencer;
  localparam logic [15:0] BASE   = 16'h0100;
  localparam int          REGION = 256;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] len;
  logic        cpu_reset_n, trigger, busy, done, error;
  logic [1:0]  err_code;

  boot_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  boot_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE(BASE), .REGION(REGION)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .len(len), .bus(bus),
    .cpu_reset_n(cpu_reset_n), .trigger(trigger), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int corrupt_addr = -1;
  int n_writes = 0, gap_writes = 0;
  int cyc = 0, clear_at = 0, trig_at = 0, trig_total = 0;
  logic busy_d = 1'b0;
  int n_cmp = 0, n_bad = 0;

  logic [7:0] img [0:511];
  int         gaps [0:511];
  bit         running;

  // Memory model: synchronous write, one-cycle read latency, optional bit-0 flip on readback.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      n_writes <= n_writes + 1;
      if (!bus.in_valid && bus.in_ready) gap_writes <= gap_writes + 1;
    end
    bus.mem_rdata <= mem[bus.mem_addr] ^ ((int'(bus.mem_addr) == corrupt_addr) ? 8'h01 : 8'h00);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_d <= busy;
    if (busy && !busy_d) clear_at <= cyc;
    if (trigger) begin
      trig_total <= trig_total + 1;
      trig_at    <= cyc - clear_at;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic run_boot(input int L, input int cidx, input logic [1:0] ecode, input int etrig);
    int idx, gcnt, guard, wr0, gw0, tr0, bad;
    wr0 = n_writes; gw0 = gap_writes; tr0 = trig_total;
    corrupt_addr = (cidx < 0) ? -1 : int'(BASE) + cidx;
    @(negedge clk);
    start = 1'b1; len = 16'(L); bus.in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (ecode == 2'b01) begin
      chk("lenerr_error_flag", int'(error), 1);
      chk("lenerr_code", int'(err_code), 1);
    end else chk("boot_busy", int'(busy), 1);
    idx = 0; gcnt = 0; guard = 0;
    while (!(done || error) && guard < 5000) begin
      if (idx < L) begin
        if (gcnt > 0) begin
          bus.in_valid = 1'b0;
          gcnt--;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = img[idx];
          if (bus.in_ready) begin
            idx++;
            if (idx < L) gcnt = gaps[idx];
          end
        end
      end else bus.in_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("boot_timeout", int'(guard < 5000), 1);
    chk("done", int'(done), int'(ecode == 2'b00));
    chk("error", int'(error), int'(ecode != 2'b00));
    chk("err_code", int'(err_code), int'(ecode));
    chk("cpu_reset_n", int'(cpu_reset_n), int'(ecode == 2'b00));
    chk("mem_sel", int'(bus.mem_sel), int'(ecode != 2'b00));
    chk("trigger_count", trig_total - tr0, (ecode == 2'b00) ? 1 : 0);
    if (ecode == 2'b00) chk("trigger_cycle", trig_at, etrig);
    chk("write_count", n_writes - wr0, (ecode == 2'b01) ? 0 : REGION + L);
    chk("gap_writes", gap_writes - gw0, 0);
    if (ecode != 2'b01) begin
      bad = 0;
      for (int i = 0; i < REGION; i++)
        if (mem[int'(BASE) + i] !== ((i < L) ? img[i] : 8'h00)) bad++;
      chk("mem_image_bad_words", bad, 0);
    end
    corrupt_addr = -1;
    running = (ecode == 2'b00);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_done", int'(done), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_cpu_reset_n", int'(cpu_reset_n), 0);
    chk("stop_mem_sel", int'(bus.mem_sel), 1);
    running = 1'b0;
  endtask

  task automatic fill_pattern(input int L);
    logic [7:0] nominal [0:3];
    nominal[0] = 8'hA9; nominal[1] = 8'h05; nominal[2] = 8'h85; nominal[3] = 8'h10;
    for (int i = 0; i < 512; i++) img[i] = 8'((i * 37 + 11) & 255);
    if (L == 4) for (int i = 0; i < 4; i++) img[i] = nominal[i];
  endtask

  typedef struct {
    int         len;
    int         gap;
    int         corrupt;
    logic [1:0] code;
    int         trig;
  } vec_t;

  initial begin
    vec_t vecs [0:7];
    int   L, cidx, etrig, ws, rs, wait_n, tr0, r;
    logic [1:0] ecode;

    vecs[0] = '{len: 4,   gap: 0, corrupt: -1, code: 2'b00, trig: 265};
    vecs[1] = '{len: 4,   gap: 3, corrupt: -1, code: 2'b00, trig: 274};
    vecs[2] = '{len: 4,   gap: 0, corrupt: 2,  code: 2'b10, trig: 0};
    vecs[3] = '{len: 300, gap: 0, corrupt: -1, code: 2'b01, trig: 0};
    vecs[4] = '{len: 4,   gap: 0, corrupt: -1, code: 2'b00, trig: 265};
    vecs[5] = '{len: 256, gap: 0, corrupt: -1, code: 2'b00, trig: 769};
    vecs[6] = '{len: 0,   gap: 0, corrupt: -1, code: 2'b00, trig: 256};
    vecs[7] = '{len: 1,   gap: 1, corrupt: -1, code: 2'b00, trig: 259};

    reset = 1'b1; start = 1'b0; stop = 1'b0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; running = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_mem_sel", int'(bus.mem_sel), 1);
    chk("rst_cpu_reset_n", int'(cpu_reset_n), 0);
    chk("rst_err_code", int'(err_code), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      if (running) do_stop();
      fill_pattern(vecs[v].len);
      for (int i = 0; i < 512; i++) gaps[i] = (i == 0) ? 0 : vecs[v].gap;
      run_boot(vecs[v].len, vecs[v].corrupt, vecs[v].code, vecs[v].trig);
    end

    // Reset in the middle of LOAD: one byte lands, the rest of the region stays cleared.
    if (running) do_stop();
    fill_pattern(4);
    tr0 = trig_total;
    start = 1'b1; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    chk("abort_reach_load", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_data = img[0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(bus.in_ready), 0);
    chk("abort_mem_sel", int'(bus.mem_sel), 1);
    chk("abort_cpu_reset_n", int'(cpu_reset_n), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_trigger", trig_total - tr0, 0);
    chk("abort_stays_idle", int'(busy | done | error), 0);
    chk("abort_partial_first", int'(mem[BASE]), int'(img[0]));
    chk("abort_partial_second", int'(mem[BASE + 16'd1]), 0);

    // Randomized boots against the checksum and timing rules.
    for (int t = 0; t < 10; t++) begin
      if (running) do_stop();
      r = $urandom_range(0, 9);
      if (r == 0)      L = 257 + $urandom_range(0, 100);
      else if (r == 1) L = 0;
      else if (r == 2) L = 256;
      else             L = $urandom_range(1, 24);
      for (int i = 0; i < 512; i++) begin
        img[i]  = 8'($urandom_range(0, 255));
        gaps[i] = (i == 0) ? 0 : $urandom_range(0, 3);
      end
      cidx = -1;
      if (L > 0 && L <= REGION && $urandom_range(0, 2) == 0) cidx = $urandom_range(0, L - 1);
      ws = 0; rs = 0; etrig = REGION;
      if (L <= REGION) begin
        for (int i = 0; i < L; i++) begin
          ws += img[i];
          rs += img[i] ^ ((i == cidx) ? 1 : 0);
        end
        if (L > 0) begin
          etrig = REGION + 2 * L + 1;
          for (int i = 1; i < L; i++) etrig += gaps[i];
        end
      end
      if (L > REGION)               ecode = 2'b01;
      else if ((ws % 256) != (rs % 256)) ecode = 2'b10;
      else                          ecode = 2'b00;
      run_boot(L, cidx, ecode, etrig);
    end
    if (running) do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
